csr_access_sequencer: RTL and testbench



---
 rtl/csr_access_sequencer.sv | 150 +++++++++++++++
 tb/tb_csr_access_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_sequencer.sv
// rtl/csr_access_sequencer.sv - CSR instruction read-modify-write sequencer
module csr_access_sequencer #(
    parameter int C_XLEN = 32
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [11:0]       req_addr_i,
    input  logic [C_XLEN-1:0] req_operand_i,
    input  logic              req_wr_suppress_i,
    input  logic              req_rd_suppress_i,
    output logic              csr_rd_o,
    output logic [11:0]       csr_rd_addr_o,
    input  logic [C_XLEN-1:0] csr_rd_data_i,
    input  logic              csr_illegal_rd_i,
    input  logic              csr_illegal_wr_i,
    output logic              csr_wr_o,
    output logic [11:0]       csr_wr_addr_o,
    output logic [C_XLEN-1:0] csr_wr_data_o,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [C_XLEN-1:0] rsp_data_o,
    output logic              rsp_exc_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EVAL = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] OP_ILL = 2'b00;
    localparam logic [1:0] OP_RW  = 2'b01;
    localparam logic [1:0] OP_RS  = 2'b10;
    localparam logic [1:0] OP_RC  = 2'b11;

    state_t             state;
    state_t             state_nxt;

    logic [1:0]         op_q;
    logic [11:0]        addr_q;
    logic [C_XLEN-1:0]  operand_q;
    logic               rd_sup_q;
    logic               wr_sup_q;
    logic [C_XLEN-1:0]  rsp_data_q;
    logic               rsp_exc_q;

    logic               accept;
    logic               eff_rd_sup;
    logic               eff_wr_sup;
    logic               exc;
    logic [C_XLEN-1:0]  old_value;
    logic [C_XLEN-1:0]  new_value;

    assign accept     = (state == IDLE) && req_valid_i;
    assign eff_rd_sup = (req_op_i == OP_RW) && req_rd_suppress_i;
    assign eff_wr_sup = ((req_op_i == OP_RS) || (req_op_i == OP_RC)) && req_wr_suppress_i;
    assign old_value  = csr_rd_data_i;

    // Exception decision and modified value, meaningful while the file's registered outputs are valid (EVAL)
    always_comb begin
        exc = (op_q == OP_ILL)
            || (!rd_sup_q && csr_illegal_rd_i)
            || (!wr_sup_q && csr_illegal_wr_i);
        case (op_q)
            OP_RS:   new_value = old_value | operand_q;
            OP_RC:   new_value = old_value & ~operand_q;
            default: new_value = operand_q;
        endcase
    end

    // State register; only advances on enabled edges, reset aborts any request in flight
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state <= IDLE;
        end else if (clk_en_i) begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode; strobes are pure functions of state so they hold while clk_en_i is low
    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        csr_rd_o    = 1'b0;
        csr_wr_o    = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                csr_rd_o  = !rd_sup_q;
                state_nxt = EVAL;
            end
            EVAL: begin
                csr_wr_o  = !exc && !wr_sup_q;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture at accept and response capture at the end of EVAL
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            op_q       <= OP_ILL;
            addr_q     <= '0;
            operand_q  <= '0;
            rd_sup_q   <= 1'b0;
            wr_sup_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_exc_q  <= 1'b0;
        end else if (clk_en_i) begin
            if (accept) begin
                op_q      <= req_op_i;
                addr_q    <= req_addr_i;
                operand_q <= req_operand_i;
                rd_sup_q  <= eff_rd_sup;
                wr_sup_q  <= eff_wr_sup;
            end
            if (state == EVAL) begin
                rsp_data_q <= (exc || rd_sup_q) ? '0 : old_value;
                rsp_exc_q  <= exc;
            end
        end
    end

    assign csr_rd_addr_o = addr_q;
    assign csr_wr_addr_o = addr_q;
    assign csr_wr_data_o = (state == EVAL) ? new_value : '0;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_exc_o     = rsp_exc_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// tb/tb_csr_access_sequencer.sv - scoreboard bench for csr_access_sequencer
module tb_csr_access_sequencer;

    logic        clk_i = 1'b0;
    logic        resetb_i = 1'b0;
    logic        clk_en_i = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [11:0] req_addr = '0;
    logic [31:0] req_operand = '0;
    logic        req_wr_sup = 1'b0;
    logic        req_rd_sup = 1'b0;
    logic        csr_rd;
    logic [11:0] csr_rd_addr;
    bit   [31:0] csr_rd_data;
    bit          csr_ill_rd;
    bit          csr_ill_wr;
    logic        csr_wr;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_exc;

    csr_access_sequencer #(.C_XLEN(32)) dut (
        .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_operand_i(req_operand),
        .req_wr_suppress_i(req_wr_sup), .req_rd_suppress_i(req_rd_sup),
        .csr_rd_o(csr_rd), .csr_rd_addr_o(csr_rd_addr), .csr_rd_data_i(csr_rd_data),
        .csr_illegal_rd_i(csr_ill_rd), .csr_illegal_wr_i(csr_ill_wr),
        .csr_wr_o(csr_wr), .csr_wr_addr_o(csr_wr_addr), .csr_wr_data_o(csr_wr_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_exc_o(rsp_exc)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {logic [11:0] a; logic [31:0] d;} wr_t;
    typedef struct {logic [31:0] d; logic e; int n_wr; int n_rd;} rsp_t;

    wr_t  exp_wr[$];
    rsp_t exp_rsp[$];
    int   errors = 0;
    int   checks = 0;

    bit [31:0] mem[4096];
    bit [31:0] ref_mem[4096];
    logic        preset_en = 1'b0;
    logic [11:0] preset_addr = '0;
    logic [31:0] preset_data = '0;

    int en_mode = 0;
    int rdy_mode = 0;

    function automatic bit is_ill_rd(input logic [11:0] a);
        return a[11:8] == 4'h8;
    endfunction

    function automatic bit is_ill_wr(input logic [11:0] a);
        return a[11:10] == 2'b11;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // CSR file model: registered query port, writes land on enabled edges
    always @(posedge clk_i) begin
        if (preset_en) mem[preset_addr] <= preset_data;
        if (clk_en_i) begin
            if (csr_wr) mem[csr_wr_addr] <= csr_wr_data;
            csr_rd_data <= mem[csr_rd_addr];
            csr_ill_rd  <= is_ill_rd(csr_rd_addr);
            csr_ill_wr  <= is_ill_wr(csr_rd_addr);
        end
    end

    // Clock-enable and response-ready drivers
    int vcnt = 0;
    always @(posedge clk_i) begin
        #1;
        case (en_mode)
            0: clk_en_i = 1'b1;
            1: clk_en_i = ~clk_en_i;
            default: clk_en_i = ($urandom_range(0, 3) != 0);
        endcase
        vcnt = rsp_valid ? vcnt + 1 : 0;
        case (rdy_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = ($urandom_range(0, 2) == 0);
            default: rsp_ready = (vcnt > 5);
        endcase
    end

    // Behavioural reference: one instruction at a time against the shadow CSR array
    task automatic model(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                         input bit ws, input bit rs);
        logic [31:0] old, nv;
        bit rd_sup, wr_sup, exc;
        rsp_t r;
        old    = ref_mem[a];
        rd_sup = (op == 2'b01) && rs;
        wr_sup = (op == 2'b10 || op == 2'b11) && ws;
        exc    = (op == 2'b00) || (!rd_sup && is_ill_rd(a)) || (!wr_sup && is_ill_wr(a));
        nv     = (op == 2'b10) ? (old | d) : (op == 2'b11) ? (old & ~d) : d;
        r.n_wr = 0;
        if (!exc && !wr_sup) begin
            exp_wr.push_back('{a: a, d: nv});
            ref_mem[a] = nv;
            r.n_wr = 1;
        end
        r.n_rd = rd_sup ? 0 : 1;
        r.d    = (exc || rd_sup) ? 32'h0 : old;
        r.e    = exc;
        exp_rsp.push_back(r);
    endtask

    // Monitor: samples on the falling edge, acts as if the following rising edge is enabled when clk_en_i is high
    int  en_cnt = 0;
    int  acc_idx = 0;
    bit  busy = 0;
    bit  seen_valid = 0;
    bit  prev_hold = 0;
    logic [31:0] prev_d = '0;
    logic prev_e = 1'b0;
    int  wr_cnt = 0;
    int  rd_cnt = 0;
    always @(negedge clk_i) begin
        if (!resetb_i) begin
            busy = 0; seen_valid = 0; prev_hold = 0; wr_cnt = 0; rd_cnt = 0;
        end else begin
            chk(req_ready == !busy, "req_ready", {31'b0, req_ready}, {31'b0, !busy});
            if (prev_hold) begin
                chk(rsp_valid == 1'b1, "rsp_valid_hold", {31'b0, rsp_valid}, 32'h1);
                chk(rsp_data == prev_d, "rsp_data_stable", rsp_data, prev_d);
                chk(rsp_exc == prev_e, "rsp_exc_stable", {31'b0, rsp_exc}, {31'b0, prev_e});
            end
            if (busy && rsp_valid && !seen_valid) begin
                chk(en_cnt == acc_idx + 3, "rsp_latency", en_cnt, acc_idx + 3);
                seen_valid = 1;
            end
            prev_hold = rsp_valid && !(clk_en_i && rsp_ready);
            prev_d = rsp_data;
            prev_e = rsp_exc;
            if (clk_en_i) begin
                if (req_valid && req_ready) begin
                    acc_idx = en_cnt; busy = 1; seen_valid = 0; wr_cnt = 0; rd_cnt = 0;
                end
                if (csr_rd) rd_cnt++;
                if (csr_wr) begin
                    wr_cnt++;
                    chk(en_cnt == acc_idx + 2, "wr_latency", en_cnt, acc_idx + 2);
                    if (exp_wr.size() == 0) begin
                        chk(0, "unexpected_write", {20'b0, csr_wr_addr}, 32'h0);
                    end else begin
                        wr_t w;
                        w = exp_wr.pop_front();
                        chk(csr_wr_addr == w.a, "wr_addr", {20'b0, csr_wr_addr}, {20'b0, w.a});
                        chk(csr_wr_data == w.d, "wr_data", csr_wr_data, w.d);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_rsp.size() == 0) begin
                        chk(0, "unexpected_rsp", rsp_data, 32'h0);
                    end else begin
                        rsp_t r;
                        r = exp_rsp.pop_front();
                        chk(rsp_data == r.d, "rsp_data", rsp_data, r.d);
                        chk(rsp_exc == r.e, "rsp_exc", {31'b0, rsp_exc}, {31'b0, r.e});
                        chk(wr_cnt == r.n_wr, "write_count", wr_cnt, r.n_wr);
                        chk(rd_cnt == r.n_rd, "read_strobes", rd_cnt, r.n_rd);
                    end
                    busy = 0;
                end
                en_cnt++;
            end
        end
    end

    task automatic preset(input logic [11:0] a, input logic [31:0] d);
        preset_addr = a; preset_data = d; preset_en = 1'b1;
        @(posedge clk_i); #1;
        preset_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic issue(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                         input bit ws, input bit rs, input bit use_model);
        int n;
        bit acc;
        if (use_model) model(op, a, d, ws, rs);
        req_valid = 1'b1; req_op = op; req_addr = a; req_operand = d;
        req_wr_sup = ws; req_rd_sup = rs;
        n = 0; acc = 0;
        while (!acc && n < 2000) begin
            @(negedge clk_i);
            acc = req_ready && clk_en_i;
            @(posedge clk_i); #1;
            n++;
        end
        if (!acc) chk(0, "accept_timeout", n, 2000);
        req_valid = 1'b0;
        req_op = 2'($urandom); req_addr = 12'($urandom); req_operand = $urandom;
        req_wr_sup = 1'($urandom); req_rd_sup = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_rsp.size() != 0 || req_valid) && n < 3000) begin
            @(posedge clk_i); n++;
        end
        #2;
        if (n >= 3000) chk(0, "drain_timeout", n, 3000);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(req_ready == 1'b1, {tag, "_req_ready"}, {31'b0, req_ready}, 32'h1);
        chk({csr_rd, csr_wr, rsp_valid, rsp_exc} == 4'b0000, {tag, "_strobes"},
            {28'b0, csr_rd, csr_wr, rsp_valid, rsp_exc}, 32'h0);
        chk({csr_rd_addr, csr_wr_addr} == 24'h0, {tag, "_addrs"}, {8'b0, csr_rd_addr, csr_wr_addr}, 32'h0);
        chk(csr_wr_data == 32'h0, {tag, "_wr_data"}, csr_wr_data, 32'h0);
        chk(rsp_data == 32'h0, {tag, "_rsp_data"}, rsp_data, 32'h0);
    endtask

    task automatic directed_set();
        preset(12'h340, 32'h12345678);
        issue(2'b01, 12'h340, 32'hDEADBEEF, 0, 0, 1);
        wait_idle();
        chk(mem[12'h340] == 32'hDEADBEEF, "rw_mem", mem[12'h340], 32'hDEADBEEF);
        preset(12'h341, 32'h000000F0);
        issue(2'b10, 12'h341, 32'h0000000F, 0, 0, 1);
        wait_idle();
        chk(mem[12'h341] == 32'h000000FF, "rs_mem", mem[12'h341], 32'h000000FF);
        issue(2'b11, 12'h341, 32'h0000000F, 0, 0, 1);
        wait_idle();
        chk(mem[12'h341] == 32'h000000F0, "rc_mem", mem[12'h341], 32'h000000F0);
        issue(2'b10, 12'h341, 32'hFFFF0000, 1, 0, 1);
        preset(12'hF11, 32'h0);
        issue(2'b01, 12'hF11, 32'hCAFEF00D, 0, 0, 1);
        issue(2'b10, 12'hF11, 32'h0, 1, 0, 1);
        issue(2'b00, 12'h340, 32'h11111111, 0, 0, 1);
        issue(2'b01, 12'h342, 32'h00000055, 0, 1, 1);
        issue(2'b01, 12'h800, 32'h00000001, 0, 0, 1);
        issue(2'b01, 12'h800, 32'h00000002, 0, 1, 1);
        wait_idle();
        chk(mem[12'hF11] == 32'h0, "ro_mem", mem[12'hF11], 32'h0);
        chk(mem[12'h342] == 32'h55, "rdsup_mem", mem[12'h342], 32'h55);
    endtask

    initial begin
        logic [11:0] addrs[7];
        addrs[0] = 12'h340; addrs[1] = 12'h341; addrs[2] = 12'h300; addrs[3] = 12'hF11;
        addrs[4] = 12'h805; addrs[5] = 12'hC00; addrs[6] = 12'h342;

        repeat (3) @(posedge clk_i);
        #2;
        check_reset_outputs("reset");
        resetb_i = 1'b1;
        @(posedge clk_i); #1;

        en_mode = 0; rdy_mode = 0;
        directed_set();

        en_mode = 1; rdy_mode = 2;
        directed_set();
        en_mode = 0; rdy_mode = 0;
        wait_idle();

        // Reset asserted during EVAL aborts the write and the response
        preset(12'h343, 32'hA5A5A5A5);
        issue(2'b01, 12'h343, 32'h5A5A5A5A, 0, 0, 0);
        @(posedge clk_i); #1;
        chk(csr_wr == 1'b1, "eval_write_before_reset", {31'b0, csr_wr}, 32'h1);
        resetb_i = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk_i);
        #1;
        resetb_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk(mem[12'h343] == 32'hA5A5A5A5, "abort_no_write", mem[12'h343], 32'hA5A5A5A5);
        issue(2'b10, 12'h343, 32'h0000000F, 0, 0, 1);
        wait_idle();
        chk(mem[12'h343] == 32'hA5A5A5AF, "post_reset_rs", mem[12'h343], 32'hA5A5A5AF);

        for (int i = 0; i < 90; i++) begin
            logic [11:0] a;
            en_mode = (i / 30);
            rdy_mode = (i % 3);
            a = ($urandom_range(0, 7) == 7) ? 12'($urandom) : addrs[$urandom_range(0, 6)];
            issue(2'($urandom), a, $urandom, 1'($urandom), 1'($urandom), 1);
        end
        wait_idle();
        chk(exp_wr.size() == 0, "wr_queue_empty", exp_wr.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0x%08h expected 0x%08h", checks, 0);
        $fatal(1, "timeout");
    end

endmodule
